// File: rtl/two_to_four_decoder_pulse_module_pkg.sv
// Shared definitions for the 2:4 pulse decoder: FSM states, the encoder's code
// constants and the code-to-line decode used by both RTL and benches.
package two_to_four_decoder_pulse_module_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  localparam logic [1:0] CODE_A = 2'b00;
  localparam logic [1:0] CODE_B = 2'b01;
  localparam logic [1:0] CODE_C = 2'b10;
  localparam logic [1:0] CODE_D = 2'b11;

  // Returns the line vector ordered {d, c, b, a}.
  function automatic logic [3:0] code_to_onehot(input logic [1:0] code);
    logic [3:0] onehot;
    onehot = '0;
    case (code)
      CODE_A:  onehot[0] = 1'b1;
      CODE_B:  onehot[1] = 1'b1;
      CODE_C:  onehot[2] = 1'b1;
      CODE_D:  onehot[3] = 1'b1;
      default: onehot = '0;
    endcase
    return onehot;
  endfunction

endpackage

// File: rtl/two_to_four_decoder_pulse_module_hold_down_counter.sv
// Loadable down counter that times how long a decoded line is held.
// Load wins over decrement; the count saturates at zero instead of wrapping.
module hold_down_counter_module
  import two_to_four_decoder_pulse_module_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/two_to_four_decoder_pulse_module.sv
// Registered 2:4 decoder: each accepted code drives its one-hot line for
// HOLD_CYCLES clocks, with a done pulse in the final drive cycle.
module two_to_four_decoder_pulse_module
  import two_to_four_decoder_pulse_module_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic code0,
  input  logic code1,
  output logic in_ready,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic busy,
  output logic done
);

  if ((HOLD_CYCLES < 1) || (HOLD_CYCLES > 255) || ((HOLD_CYCLES >> CNT_W) != 0))
  begin : g_bad_params
    $error("HOLD_CYCLES must be 1..255 and fit in CNT_W bits");
  end

  state_t           state;
  logic [1:0]       code_q;
  logic [3:0]       lines_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;

  logic             handshake;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;

  assign handshake = (state == IDLE) && in_valid;

  hold_down_counter_module #(
    .CNT_W(CNT_W)
  ) u_hold_cnt (
    .clk       (clk),
    .reset     (reset),
    .load      (handshake),
    .load_value(CNT_W'(HOLD_CYCLES - 1)),
    .dec       (state == DRIVE),
    .count     (cnt),
    .zero      (cnt_zero)
  );

  // done is registered one cycle ahead: it is set on the edge that brings the
  // counter to zero (or on the handshake itself when HOLD_CYCLES is 1).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      code_q  <= CODE_A;
      lines_q <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state   <= DRIVE;
            code_q  <= {code1, code0};
            lines_q <= code_to_onehot({code1, code0});
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= (HOLD_CYCLES == 1);
          end
        end
        DRIVE: begin
          if (cnt_zero) begin
            state   <= IDLE;
            lines_q <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else begin
            done_q  <= (cnt == CNT_W'(1));
          end
        end
        default: begin
          state   <= IDLE;
          lines_q <= '0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  a_line_matches_code: assert property (
    @(posedge clk) disable iff (reset)
    (state == DRIVE) |-> (lines_q == code_to_onehot(code_q))
  );

  assign in_ready = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign a        = lines_q[0];
  assign b        = lines_q[1];
  assign c        = lines_q[2];
  assign d        = lines_q[3];

endmodule

// File: tb/tb_two_to_four_decoder_pulse_module.sv
// Scoreboard bench: two decoders (hold 4 and hold 1) share stimulus; a window
// model predicts each strobe and a negedge monitor checks every cycle.
module tb_two_to_four_decoder_pulse_module;

  localparam int HOLD4 = 4;
  localparam int HOLD1 = 1;

  typedef struct {
    int         inst;
    logic [1:0] code;
    int         start;
  } txn_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic code0 = 1'b0;
  logic code1 = 1'b0;

  logic       rdy4, a4, b4, c4, d4, busy4, done4;
  logic       rdy1, a1, b1, c1, d1, busy1, done1;

  int         checks = 0;
  int         passes = 0;
  int         edge_n = 0;
  int         hold_of [2] = '{HOLD4, HOLD1};
  int         free_at [2] = '{0, 0};
  txn_t       sb [$];

  always #5 clk = ~clk;

  two_to_four_decoder_pulse_module #(.HOLD_CYCLES(HOLD4), .CNT_W(8)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .code0(code0), .code1(code1),
    .in_ready(rdy4), .a(a4), .b(b4), .c(c4), .d(d4), .busy(busy4), .done(done4)
  );

  two_to_four_decoder_pulse_module #(.HOLD_CYCLES(HOLD1), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .code0(code0), .code1(code1),
    .in_ready(rdy1), .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s t=%0t: got {rdy,busy,done,d,c,b,a}=%b expected %b",
                  name, $time, act, exp);
  endtask

  function automatic logic [6:0] observed(input int inst);
    if (inst == 0) return {rdy4, busy4, done4, d4, c4, b4, a4};
    return {rdy1, busy1, done1, d1, c1, b1, a1};
  endfunction

  // Reference: an accept at edge T lights code's line for edges T..T+H-1
  // (sampled after each edge), and the block is free again at edge T+H+1.
  always @(posedge reset) begin
    sb.delete();
    free_at[0] = 0;
    free_at[1] = 0;
  end

  always @(posedge clk) begin
    edge_n++;
    if (!reset && in_valid === 1'b1) begin
      for (int i = 0; i < 2; i++) begin
        if (edge_n >= free_at[i]) begin
          sb.push_back('{i, {code1, code0}, edge_n});
          free_at[i] = edge_n + hold_of[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    int         idx;
    int         last;
    logic [6:0] exp;
    for (int i = 0; i < 2; i++) begin
      idx = -1;
      foreach (sb[k]) if (sb[k].inst == i) idx = k;
      exp = 7'b100_0000;
      if (idx >= 0) begin
        last = sb[idx].start + hold_of[i] - 1;
        if (edge_n >= sb[idx].start && edge_n <= last) begin
          exp = 7'b000_0000;
          exp[sb[idx].code] = 1'b1;
          exp[5] = 1'b1;
          exp[4] = (edge_n == last);
        end
        if (edge_n >= last) sb.delete(idx);
      end
      chk(i == 0 ? "cycle_hold4" : "cycle_hold1", observed(i), exp);
    end
  end

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    {code1, code0} = 2'bxx;
    repeat (n) @(negedge clk);
  endtask

  task automatic offer(input logic [1:0] code, input int n);
    in_valid = 1'b1;
    {code1, code0} = code;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle with X on the code inputs
    idle_cycles(10);

    // Single code 10
    offer(2'b10, 1);
    idle_cycles(7);

    // Back-to-back sweep with in_valid held high
    for (int cde = 0; cde < 4; cde++) offer(2'(cde), HOLD4 + 1);
    idle_cycles(6);

    // Code 11 offered while code 01 is driving must be ignored
    offer(2'b01, 1);
    offer(2'b11, 3);
    idle_cycles(6);

    // Async reset in the second drive cycle of code 11
    offer(2'b11, 1);
    in_valid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("reset_immediate_hold4", observed(0), 7'b100_0000);
    chk("reset_immediate_hold1", observed(1), 7'b100_0000);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    offer(2'b00, 1);
    idle_cycles(6);

    // Continuous offers of code 00: hold-1 instance accepts every 2 cycles
    offer(2'b00, 6);
    idle_cycles(6);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      {code1, code0} = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    idle_cycles(8);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/two_to_four_decoder_pulse_module.md
Name: two_to_four_decoder_pulse_module

Overview:
Registered 2:4 decoder that is the receive end of the 4:2 priority encoder's code (code1 = c|d, code0 = bc'|d).
- Accepts one 2-bit code per valid/ready handshake.
- Drives the matching one-hot line (a/b/c/d) for exactly HOLD_CYCLES clocks, then signals completion.
- Used where the encoded request must be replayed as a timed strobe to the downstream unit.

Parameters:
HOLD_CYCLES, 4, cycles each one-hot line stays high per accepted code; legal range 1..255.
CNT_W, 8, hold counter width; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  code0/code1 carry a code this cycle
code0  input  1  code LSB (encoder out0)
code1  input  1  code MSB (encoder out1)
in_ready  output  1  block can accept a code this cycle
a  output  1  one-hot line for code 00
b  output  1  one-hot line for code 01
c  output  1  one-hot line for code 10
d  output  1  one-hot line for code 11
busy  output  1  a line is currently being driven
done  output  1  single-cycle pulse in the last drive cycle

Behaviour:
- Reset (async, active-high): state IDLE, counter 0, captured code 00, a=b=c=d=0, busy=0, done=0, in_ready=1. Takes effect immediately, including mid-drive. The active line drops without a done pulse.
- Two states, localparams IDLE and DRIVE.
- IDLE:
  - in_ready=1, busy=0, all lines 0.
  - A handshake is in_valid&&in_ready at a rising edge. On it: capture {code1,code0}, load counter with HOLD_CYCLES-1, go to DRIVE.
  - in_valid low: stay IDLE; code inputs ignored.
- DRIVE:
  - in_ready=0, busy=1.
  - Exactly one line is high, selected by the captured code: 00->a, 01->b, 10->c, 11->d. Never two lines high, never a glitch between lines.
  - in_valid and the code inputs are ignored; no queuing.
  - Counter decrements each cycle.
  - When counter==0: done=1 for that cycle, and the next edge returns to IDLE with all lines 0.
- Latency: the line rises in the first cycle after the handshake edge. It stays high for exactly HOLD_CYCLES consecutive cycles.
- Throughput: next accept is no earlier than the first IDLE cycle after the drive. Minimum handshake spacing is HOLD_CYCLES+1 cycles.
- HOLD_CYCLES=1: line high for one cycle, with done in that same cycle.
- All outputs are registered or pure decodes of registered state; none depend combinationally on in_valid or the code inputs.
- in_ready is a decode of state only; it never depends on in_valid.
- in_valid is sampled only at rising clock edges; X on the code inputs while in_valid=0 must not propagate.
- Counter never wraps: it only loads on a handshake and decrements only while nonzero in DRIVE.

Decomposition:
- Shared include header holds:
  - the state localparams (IDLE=1'b0, DRIVE=1'b1);
  - the code constants (CODE_A=2'b00, CODE_B=2'b01, CODE_C=2'b10, CODE_D=2'b11), shared with the encoder bench.
- One natural sub-module: hold_down_counter_module. It is a CNT_W-bit loadable down counter (load, load_value, dec, zero flag) with the same clk/reset. The FSM and one-hot decode stay in the top.

Test Plan:
1. Reset then idle, in_valid=0 for 10 cycles -> a=b=c=d=0, busy=0, done=0, in_ready=1 throughout.
2. HOLD_CYCLES=4; handshake with code 10 at edge T -> c=1 on cycles T+1..T+4 and a=b=d=0; done=1 only at T+4; in_ready=1 again at T+5.
3. Sweep codes 00,01,10,11 back-to-back with in_valid held high -> a, b, c, d each high for exactly 4 cycles; one idle cycle between strobes; accepts spaced 5 cycles apart.
4. During DRIVE of code 01, present in_valid=1 with code 11 -> ignored: b stays high its full 4 cycles, d never rises, in_ready stays 0.
5. Reset asserted asynchronously between edges on the 2nd drive cycle of code 11 -> d falls immediately, no done pulse; after release in_ready=1, and a new code 00 produces a 4-cycle pulse on a.
6. HOLD_CYCLES=1; handshake with code 00 -> a high for exactly 1 cycle with done=1 that same cycle; next accept allowed 2 cycles after the first.
